// File: rtl/sdram_arbiter.sv
// sdram_arbiter: one write + NUM_READ_PORTS read requesters share one SDRAM
// controller port with a single outstanding transaction; read data is routed
// back to the port that issued it. The write port always beats the reads.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin reads; without it reads use
// fixed priority, where the lowest index wins.
// Ports:
//   clk, reset_n (async, active low)
//   wr_req/wr_addr/wr_data/wr_ack          write requester
//   rd_req/rd_addr/rd_ack/rd_valid/rd_data read requesters (packed addr)
//   ctrl_req/ctrl_we/ctrl_addr/ctrl_din    request to the controller
//   ctrl_ack/ctrl_valid/ctrl_dout          controller responses
module sdram_arbiter #(
  parameter int NUM_READ_PORTS = 4,
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_req,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               wr_ack,
  input  logic [NUM_READ_PORTS-1:0]          rd_req,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS-1:0]          rd_ack,
  output logic [NUM_READ_PORTS-1:0]          rd_valid,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               ctrl_req,
  output logic                               ctrl_we,
  output logic [ADDR_WIDTH-1:0]              ctrl_addr,
  output logic [DATA_WIDTH-1:0]              ctrl_din,
  input  logic                               ctrl_ack,
  input  logic                               ctrl_valid,
  input  logic [DATA_WIDTH-1:0]              ctrl_dout
);

  localparam int OW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_n;

  logic [OW-1:0]             owner;
  logic [OW-1:0]             pick;
  logic                      any_rd;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic                      start;
  logic [NUM_READ_PORTS-1:0] owner_oh;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Holds the port where the next search begins (last grant + 1),
  // so the first search after reset starts at port 0.
  logic [OW-1:0] rr_ptr;
  int            j;

  always_comb begin
    pick     = '0;
    any_rd   = 1'b0;
    sel_addr = '0;
    j        = 0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_READ_PORTS) j = j - NUM_READ_PORTS;
      if (!any_rd && rd_req[j]) begin
        any_rd   = 1'b1;
        pick     = OW'(j);
        sel_addr = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (start && !wr_req) begin
      if (pick == OW'(NUM_READ_PORTS-1)) rr_ptr <= '0;
      else rr_ptr <= pick + 1'b1;
    end
  end
`else
  // Descending scan: the lowest requesting index is written last.
  always_comb begin
    pick     = '0;
    any_rd   = 1'b0;
    sel_addr = '0;
    for (int i = NUM_READ_PORTS-1; i >= 0; i--) begin
      if (rd_req[i]) begin
        any_rd   = 1'b1;
        pick     = OW'(i);
        sel_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end
`endif

  assign start = (state == IDLE) && (wr_req || any_rd);

  always_comb begin
    for (int i = 0; i < NUM_READ_PORTS; i++)
      owner_oh[i] = (owner == OW'(i));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (wr_req || any_rd) state_n = REQ;
      REQ:  if (ctrl_ack) state_n = ctrl_we ? IDLE : WAIT;
      WAIT: if (ctrl_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_req  <= 1'b0;
      ctrl_we   <= 1'b0;
      ctrl_addr <= '0;
      ctrl_din  <= '0;
      owner     <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      ctrl_req <= (state_n == REQ);
      wr_ack   <= 1'b0;
      rd_ack   <= '0;
      rd_valid <= '0;
      if (start) begin
        ctrl_we   <= wr_req;
        ctrl_addr <= wr_req ? wr_addr : sel_addr;
        ctrl_din  <= wr_data;
        if (!wr_req) owner <= pick;
      end
      if (state == REQ && ctrl_ack) begin
        if (ctrl_we) wr_ack <= 1'b1;
        else rd_ack <= owner_oh;
      end
      if (state == WAIT && ctrl_valid) begin
        rd_valid <= owner_oh;
        rd_data  <= ctrl_dout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter (4 read ports).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sdram_arbiter;

  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_req = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_ack;
  logic [N-1:0]    rd_req = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]    rd_ack;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            ctrl_req;
  logic            ctrl_we;
  logic [AW-1:0]   ctrl_addr;
  logic [DW-1:0]   ctrl_din;
  logic            ctrl_ack = 1'b0;
  logic            ctrl_valid = 1'b0;
  logic [DW-1:0]   ctrl_dout = '0;

  int ntests = 0;
  int nfail  = 0;
  int nacks;

  sdram_arbiter #(.NUM_READ_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
    .ctrl_din(ctrl_din), .ctrl_ack(ctrl_ack), .ctrl_valid(ctrl_valid),
    .ctrl_dout(ctrl_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // One read for port p: grant, ack after ad extra REQ cycles, data after
  // vd extra WAIT cycles. keep=1 leaves the request asserted.
  task automatic serve_read(input int p, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int ad,
                            input int vd, input bit keep);
    logic [N-1:0] oh;
    oh = N'(1) << p;
    tick();
    chk("grant_req", {63'd0, ctrl_req}, 64'd1);
    chk("grant_we", {63'd0, ctrl_we}, 64'd0);
    chk("grant_addr", 64'(ctrl_addr), 64'(a));
    for (int k = 0; k < ad; k++) begin
      tick();
      chk("req_hold", {63'd0, ctrl_req}, 64'd1);
      chk("addr_hold", 64'(ctrl_addr), 64'(a));
    end
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    chk("rd_ack", 64'(rd_ack), 64'(oh));
    chk("req_drop", {63'd0, ctrl_req}, 64'd0);
    if (!keep) rd_req[p] = 1'b0;
    for (int k = 0; k < vd; k++) begin
      tick();
      chk("rd_ack_once", 64'(rd_ack), 64'd0);
    end
    ctrl_dout  = d;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    chk("rd_valid", 64'(rd_valid), 64'(oh));
    chk("rd_data", 64'(rd_data), 64'(d));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_req", {63'd0, ctrl_req}, 64'd0);
    chk("rst_we", {63'd0, ctrl_we}, 64'd0);
    chk("rst_addr", 64'(ctrl_addr), 64'd0);
    chk("rst_din", 64'(ctrl_din), 64'd0);
    chk("rst_acks", {59'd0, wr_ack, rd_ack}, 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single read on port 2: ack 3 cycles after ctrl_req, data 2 later
    rd_addr[2*AW +: AW] = 23'h001234;
    rd_req = 4'b0100;
    serve_read(2, 23'h001234, 32'hDEADBEEF, 2, 1, 1'b0);
    tick();
    chk("rd_valid_once", 64'(rd_valid), 64'd0);
    chk("rd_data_hold", 64'(rd_data), 64'hDEADBEEF);
    chk("idle_req", {63'd0, ctrl_req}, 64'd0);

    // Write priority over all four reads
    rd_addr[0*AW +: AW] = 23'h000100;
    rd_addr[1*AW +: AW] = 23'h000111;
    rd_addr[3*AW +: AW] = 23'h000333;
    wr_addr = 23'h000ABC;
    wr_data = 32'hA5A5A5A5;
    wr_req  = 1'b1;
    rd_req  = 4'b1111;
    tick();
    chk("wp_req", {63'd0, ctrl_req}, 64'd1);
    chk("wp_we", {63'd0, ctrl_we}, 64'd1);
    chk("wp_din", 64'(ctrl_din), 64'hA5A5A5A5);
    chk("wp_addr", 64'(ctrl_addr), 64'h000ABC);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    chk("wp_wr_ack", {63'd0, wr_ack}, 64'd1);
    chk("wp_no_rd_ack", 64'(rd_ack), 64'd0);
    wr_req = 1'b0;
    serve_read(0, 23'h000100, 32'h00C0FFEE, 0, 0, 1'b0);
    rd_req = 4'b0000;
    tick();

    // Ignored strobes: valid in IDLE, ack in WAIT
    ctrl_dout  = 32'h12345678;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    chk("ign_valid", 64'(rd_valid), 64'd0);
    chk("ign_data", 64'(rd_data), 64'h00C0FFEE);
    chk("ign_req", {63'd0, ctrl_req}, 64'd0);
    rd_req = 4'b0010;
    tick();
    chk("ign_grant", {63'd0, ctrl_req}, 64'd1);
    ctrl_ack = 1'b1;
    tick();
    chk("ign_ack1", 64'(rd_ack), 64'd2);
    rd_req = 4'b0000;
    tick();
    ctrl_ack = 1'b0;
    chk("ign_ack2", 64'(rd_ack), 64'd0);
    chk("ign_req2", {63'd0, ctrl_req}, 64'd0);
    ctrl_dout  = 32'h0BADF00D;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    chk("ign_wait_kept", 64'(rd_valid), 64'd2);
    chk("ign_wait_data", 64'(rd_data), 64'h0BADF00D);

    // Reset in the middle of a read
    rd_req = 4'b0100;
    tick();
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    rd_req = 4'b0000;
    reset_n = 1'b0;
    #1;
    chk("mr_req", {63'd0, ctrl_req}, 64'd0);
    chk("mr_addr", 64'(ctrl_addr), 64'd0);
    chk("mr_din", 64'(ctrl_din), 64'd0);
    chk("mr_acks", {59'd0, wr_ack, rd_ack}, 64'd0);
    chk("mr_data", 64'(rd_data), 64'd0);
    tick();
    reset_n = 1'b1;
    ctrl_dout  = 32'hFFFF0000;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    chk("mr_stale", 64'(rd_valid), 64'd0);
    rd_req = 4'b0001;
    serve_read(0, 23'h000100, 32'h5A5A0001, 1, 0, 1'b0);

    // Contention on ports 1 and 3
    do_reset();
    rd_req = 4'b1010;
    serve_read(1, 23'h000111, 32'h11111111, 0, 0, 1'b0);
    serve_read(3, 23'h000333, 32'h33333333, 0, 0, 1'b0);
    rd_req = 4'b0000;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    do_reset();
    rd_req = 4'b1111;
    serve_read(0, 23'h000100, 32'hA0, 0, 0, 1'b1);
    serve_read(1, 23'h000111, 32'hA1, 0, 0, 1'b1);
    serve_read(2, 23'h001234, 32'hA2, 0, 0, 1'b1);
    serve_read(3, 23'h000333, 32'hA3, 0, 0, 1'b1);
    serve_read(0, 23'h000100, 32'hA4, 0, 0, 1'b1);
    rd_req = 4'b0000;
`else
    // Fixed priority keeps picking port 0 while it is held
    do_reset();
    rd_req = 4'b1111;
    serve_read(0, 23'h000100, 32'hB0, 0, 0, 1'b1);
    serve_read(0, 23'h000100, 32'hB1, 0, 0, 1'b1);
    rd_req = 4'b0000;
`endif
    tick();

    // Back-to-back writes, acked in the first REQ cycle
    nacks   = 0;
    wr_req  = 1'b1;
    wr_addr = 23'h000777;
    for (int w = 0; w < 3; w++) begin
      wr_data = 32'hC0DE0000 + w;
      tick();
      chk("bb_req_up", {63'd0, ctrl_req}, 64'd1);
      chk("bb_din", 64'(ctrl_din), 64'(32'hC0DE0000 + w));
      chk("bb_no_ack", {63'd0, wr_ack}, 64'd0);
      ctrl_ack = 1'b1;
      tick();
      ctrl_ack = 1'b0;
      chk("bb_req_down", {63'd0, ctrl_req}, 64'd0);
      if (wr_ack) nacks++;
      if (w == 2) wr_req = 1'b0;
    end
    tick();
    chk("bb_idle", {63'd0, ctrl_req}, 64'd0);
    chk("bb_acks", 64'(nacks), 64'd3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
